// File: rtl/mips_muldiv.sv
// -----------------------------------------------------------------------------
// mips_muldiv
//   Iterative multiply/divide unit for the MIPS execute stage. Runs
//   MULT/MULTU/DIV/DIVU one radix-2 step per cycle and holds the results in the
//   architectural HI/LO registers (read by MFHI/MFLO, written by MTHI/MTLO).
//
//   Optional build macro:
//     MULDIV_EARLY_OUT_EN - multiplies leave RUN once the remaining multiplier
//                           bits are all zero (minimum one iteration).
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   A, B     operands (multiplicand/dividend, multiplier/divisor)
//   Start    launch Op; sampled only while idle
//   Op       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   HIWrite  MTHI: HI <= WData (idle and Start=0 only)
//   LOWrite  MTLO: LO <= WData (idle and Start=0 only)
//   WData    MTHI/MTLO data
//   Busy     operation in progress (pipeline stall)
//   Done     one-cycle pulse when HI/LO carry a new result
//   HI, LO   high product / remainder, low product / quotient
// -----------------------------------------------------------------------------
module mips_muldiv #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic [Width-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic [Width-1:0] HI,
  output logic [Width-1:0] LO
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  localparam int CW = $clog2(Width);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_nxt;
  logic   busy_nxt, done_nxt;

  logic [CW-1:0]      cnt;
  logic               is_div_q;   // latched Op[1]
  logic               sign_a_q;   // dividend sign (signed ops only)
  logic               neg_q;      // product / quotient must be negated
  logic               dz_q;       // divisor was zero

  // Shared working registers:
  //   multiply: acc = partial product, mcand = |A| shifted left, wrk = |B| shifted right
  //   divide:   acc[Width-1:0] = remainder, mcand[Width-1:0] = |B|,
  //             wrk = dividend shifting out at the top / quotient shifting in at the bottom
  logic [2*Width-1:0] acc, mcand;
  logic [Width-1:0]   wrk;

  // Operand magnitudes at the accepting edge
  logic             sa, sb;
  logic [Width-1:0] mag_a, mag_b;
  assign sa    = Op[0] & A[Width-1];
  assign sb    = Op[0] & B[Width-1];
  assign mag_a = sa ? -A : A;
  assign mag_b = sb ? -B : B;

  // One iteration of each algorithm
  logic [2*Width-1:0] mul_acc;
  logic [Width-1:0]   mul_wrk;
  logic [Width:0]     div_shift, div_diff;
  assign mul_acc   = wrk[0] ? acc + mcand : acc;
  assign mul_wrk   = wrk >> 1;
  assign div_shift = {acc[Width-1:0], wrk[Width-1]};
  assign div_diff  = div_shift - {1'b0, mcand[Width-1:0]};

  logic last_iter;
  assign last_iter = (cnt == CW'(Width - 1)) ||
                     (EarlyOut && !is_div_q && (mul_wrk == '0));

  // Sign fix-up. With a zero divisor the remainder path holds |A|, so
  // re-applying sign(A) returns A unchanged.
  logic [2*Width-1:0] prod_s;
  logic [Width-1:0]   quo_s, rem_s;
  assign prod_s = neg_q ? -acc : acc;
  assign quo_s  = dz_q ? '1 : (neg_q ? -wrk : wrk);
  assign rem_s  = sign_a_q ? -acc[Width-1:0] : acc[Width-1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= busy_nxt;
      Done  <= done_nxt;
    end
  end

  // FSM: next state
  // NOTE: the default assignment before the case keeps this block purely
  // combinational; without it an unassigned path would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (registered in the state process)
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == FIX);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      wrk      <= '0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            cnt      <= '0;
            is_div_q <= Op[1];
            sign_a_q <= sa;
            neg_q    <= sa ^ sb;
            dz_q     <= (B == '0);
            acc      <= '0;
            mcand    <= {{Width{1'b0}}, (Op[1] ? mag_b : mag_a)};
            wrk      <= Op[1] ? mag_a : mag_b;
          end else begin
            if (HIWrite) HI <= WData;
            if (LOWrite) LO <= WData;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div_q) begin
            // Restoring step: keep the trial difference only if it did not borrow
            if (!div_diff[Width]) begin
              acc[Width-1:0] <= div_diff[Width-1:0];
              wrk            <= {wrk[Width-2:0], 1'b1};
            end else begin
              acc[Width-1:0] <= div_shift[Width-1:0];
              wrk            <= {wrk[Width-2:0], 1'b0};
            end
          end else begin
            acc   <= mul_acc;
            mcand <= mcand << 1;
            wrk   <= mul_wrk;
          end
        end
        FIX: begin
          if (is_div_q) begin
            HI <= rem_s;
            LO <= quo_s;
          end else begin
            {HI, LO} <= prod_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// -----------------------------------------------------------------------------
// tb_mips_muldiv
//   Self-checking bench for mips_muldiv (Width=32). Expected HI/LO come from
//   plain 64-bit arithmetic; expected latency from the operand bit length.
//   Honours MULDIV_EARLY_OUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mips_muldiv;
  localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  A, B, WData;
  logic          Start, HIWrite, LOWrite;
  logic [1:0]    Op;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int total  = 0;
  int passed = 0;

  mips_muldiv #(.Width(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Start(Start), .Op(Op),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .WData(WData),
    .Busy(busy), .Done(done), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference result {HI, LO}
  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] op);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      2'b00: return ua * ub;
      2'b01: return sa * sb;
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Edges from the accepting edge until Done is visible
  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
    logic [W-1:0] mag;
    int           bits;
    if (EARLY && !op[1]) begin
      mag  = (op[0] && b[W-1]) ? -b : b;
      bits = 1;
      for (int i = 0; i < W; i++) if (mag[i]) bits = i + 1;
      return bits + 1;
    end
    return W + 1;
  endfunction

  // Launch one operation (caller is mid-cycle, design idle) and check it.
  // poke=1 keeps hammering Start with junk operands during the first cycles.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input bit poke, input string tag);
    logic [63:0] exp;
    int          n, busy_cnt, el;
    exp = model(a, b, op);
    el  = exp_lat(op, b);
    A = a; B = b; Op = op; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom; Op = 2'($urandom);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    busy_cnt = busy ? 1 : 0;
    n = 0;
    while (!done && n < 100) begin
      if (poke && n < 4) begin
        Start = 1'b1; A = $urandom; B = $urandom; Op = 2'($urandom);
      end else begin
        Start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, 64'(n), 64'(el));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(el));
    check({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    int           n;

    rst_n = 1'b0; Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
    A = '0; B = '0; Op = '0; WData = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {60'd0, busy, done, 2'b00}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0, "multu_max");
    do_op(32'hFFFF_FFFD, 32'd5,         2'b01, 1'b0, "mult_neg");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 1'b0, "div_ovf");
    do_op(32'hFFFF_FFF9, 32'd2,         2'b11, 1'b0, "div_neg");
    do_op(32'd7,         32'd2,         2'b10, 1'b0, "divu_small");
    do_op(32'h0000_1234, 32'd0,         2'b10, 1'b0, "divu_zero");
    do_op(32'hFFFF_FFF9, 32'd0,         2'b11, 1'b0, "div_zero_neg");
    do_op(32'h8000_0000, 32'h8000_0000, 2'b01, 1'b0, "mult_minmin");
    do_op(32'd3,         32'd5,         2'b00, 1'b0, "multu_3x5");
    do_op(32'h0000_ABCD, 32'd0,         2'b00, 1'b0, "multu_b0");
    do_op(32'h1234_5678, 32'hFFFF_FFFE, 2'b01, 1'b1, "start_while_busy");

    // MTHI / MTLO while idle
    HIWrite = 1'b1; WData = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    HIWrite = 1'b0;
    check("mthi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
    LOWrite = 1'b1; WData = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    LOWrite = 1'b0;
    check("mtlo", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);

    // MTHI together with Start: Start wins, HI untouched at that edge
    HIWrite = 1'b1; WData = 32'h1234_5678; Start = 1'b1; Op = 2'b00; A = 32'd2; B = 32'd3;
    @(posedge clk); #1;
    HIWrite = 1'b0; Start = 1'b0;
    check("mthi_vs_start", 64'(hi), 64'h0000_0000_A5A5_A5A5);
    // MTHI/MTLO during the busy period are ignored
    n = 0;
    while (!done && n < 100) begin
      HIWrite = (n < 20); LOWrite = (n < 20); WData = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      n++;
    end
    HIWrite = 1'b0; LOWrite = 1'b0;
    check("mt_while_busy", {hi, lo}, 64'd6);

    // Randomised operations against the model
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      do_op(ra, rb, rop, 1'b0, $sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of an operation
    A = 32'hFFFF_0001; B = 32'h0F0F_0F0F; Op = 2'b00; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {62'd0, busy, done}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'd100, 32'd7, 2'b10, 1'b0, "after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
